pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 16: length in cycles of each pll_rst assertion (minimum 2).
REQ-002 Parameter SETTLE_CYCLES, default 1024: number of cycles of stable lock required before release (minimum 1).
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: lock wait limit, 1 ms at 50 MHz (minimum 1).
REQ-004 Parameter MAX_RETRIES, default 3: number of timed-out lock attempts before FAIL (1..15).
REQ-005 Port refclk, input, 1: the single clock; the 50 MHz reference that also feeds the PLL.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port pll_locked, input, 1: PLL locked status, asynchronous to refclk.
REQ-008 Port force_relock, input, 1: single-cycle request to re-run the lock sequence.
REQ-009 Port pll_rst, output, 1: reset to the PLL, active-high.
REQ-010 Port sys_rst, output, 1: downstream system reset, active-high.
REQ-011 Port ready, output, 1: PLL locked and settled.
REQ-012 Port lock_lost, output, 1: one-cycle pulse on loss of lock while in RUN.
REQ-013 Port fail, output, 1: lock could not be achieved within MAX_RETRIES.
REQ-014 Port retry_count, output, 4: timed-out attempts since the last success.
REQ-015 Port relock_count, output, 8: saturating count of lock losses seen in RUN.

Function
REQ-016 pll_locked SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value (locked_s).
REQ-017 The FSM SHALL have states PLL_RST, WAIT_LOCK, SETTLE, RUN and FAIL; all outputs SHALL be registered.
REQ-018 PLL_RST: pll_rst=1 and sys_rst=1 for exactly RST_PULSE_CYCLES cycles, then -> WAIT_LOCK.
REQ-019 WAIT_LOCK: pll_rst=0 and sys_rst=1; locked_s=1 -> SETTLE with the settle counter cleared.
REQ-020 SETTLE: if locked_s=0 -> WAIT_LOCK (counter cleared); after SETTLE_CYCLES consecutive locked_s=1 cycles -> RUN.
REQ-021 Entering RUN: sys_rst=0, ready=1 and retry_count cleared, all on the same edge.
REQ-022 RUN: locked_s=0 -> PLL_RST; on the next edge: ready=0, sys_rst=1, lock_lost pulses for 1 cycle and relock_count increments (saturating at 255).
REQ-023 force_relock=1 in any state other than PLL_RST -> PLL_RST on the next edge; if in RUN, lock_lost SHALL NOT pulse.
REQ-024 If force_relock and loss of lock coincide in RUN, loss of lock wins: lock_lost pulses and relock_count increments.
REQ-025 Once pll_locked rises and stays high, ready SHALL assert within 2 + 1 + SETTLE_CYCLES cycles.

Reset
REQ-026 While rst=1: state=PLL_RST, pll_rst=1, sys_rst=1, ready=0, lock_lost=0, fail=0, retry_count=0, relock_count=0, all counters cleared.
REQ-027 After rst is released, the block SHALL start a full RST_PULSE_CYCLES pulse; rst asserted mid-sequence SHALL abort it immediately.

Configuration
REQ-028 With macro PLL_SUPERVISOR_TIMEOUT_EN defined, the lock timeout SHALL apply as follows:
- WAIT_LOCK that runs TIMEOUT_CYCLES cycles increments retry_count.
- It then goes to PLL_RST, or to FAIL if retry_count reaches MAX_RETRIES.
- FAIL holds fail=1, pll_rst=0 and sys_rst=1, and exits only on rst or force_relock (-> PLL_RST, fail=0, retry_count=0).
REQ-029 With the macro undefined:
- WAIT_LOCK waits indefinitely.
- FAIL is unreachable.
- fail and retry_count are tied to 0.
- No timeout counter is synthesized.

Structure
REQ-030 Package pll_sup_pkg SHALL hold the state enum type and the default parameter constants.
REQ-031 The synchronizer SHALL be a sub-module named sync_2ff (1 bit, reset value 0).

Verification
REQ-032 The bench SHALL use RST_PULSE_CYCLES=4, SETTLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2 and cover these directed scenarios:
- Release rst, then raise pll_locked 10 cycles later -> pll_rst high 4 cycles; ready=1 and sys_rst=0 exactly 11 cycles after pll_locked rises.
- In RUN, drop pll_locked -> lock_lost pulses once, relock_count=1, sys_rst=1, then pll_rst pulse of 4 cycles; relock after pll_locked returns.
- In SETTLE, glitch pll_locked low for 3 cycles at settle count 5 -> returns to WAIT_LOCK; full 8-cycle settle restarts.
- Macro defined, pll_locked held 0 -> two 32-cycle timeouts, retry_count 1 then 2, fail=1 with pll_rst=0; force_relock -> fail=0, new pll_rst pulse.
- In RUN, force_relock and pll_locked drop in the same cycle -> lock_lost=1, relock_count increments; force_relock alone -> no lock_lost pulse.
- Assert rst during SETTLE -> all outputs return to reset values asynchronously; relock_count=0.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and default configuration for the PLL lock supervisor.
package pll_sup_pkg;

    localparam int unsigned RST_PULSE_CYCLES_DEF = 16;
    localparam int unsigned SETTLE_CYCLES_DEF    = 1024;
    localparam int unsigned TIMEOUT_CYCLES_DEF   = 50000;
    localparam int unsigned MAX_RETRIES_DEF      = 3;
    localparam int unsigned RETRY_W              = 4;
    localparam int unsigned RELOCK_W             = 8;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock wait and settle before releasing the system reset.
// Lock timeout / retry / FAIL handling is built only with PLL_SUPERVISOR_TIMEOUT_EN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES = RST_PULSE_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES    = SETTLE_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES   = TIMEOUT_CYCLES_DEF,
    parameter int unsigned MAX_RETRIES      = MAX_RETRIES_DEF
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                force_relock,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                ready,
    output logic                lock_lost,
    output logic                fail,
    output logic [RETRY_W-1:0]  retry_count,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int unsigned CNT_MAX = (RST_PULSE_CYCLES > SETTLE_CYCLES) ? RST_PULSE_CYCLES
                                                                          : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    if (RST_PULSE_CYCLES < 2 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_params
        $error("pll_lock_supervisor: parameter out of range");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             locked_s;

    sync_2ff u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

`ifdef PLL_SUPERVISOR_TIMEOUT_EN
    localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TCNT_W-1:0] tcnt;
`else
    assign fail        = 1'b0;
    assign retry_count = '0;
`endif

    // cnt times both the PLL reset pulse and the settle window; they never overlap
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state        <= ST_PLL_RST;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
            lock_lost    <= 1'b0;
            relock_count <= '0;
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
            tcnt         <= '0;
            retry_count  <= '0;
            fail         <= 1'b0;
`endif
        end else begin
            lock_lost <= 1'b0;
            case (state)
                ST_PLL_RST: begin
                    if (cnt == CNT_W'(RST_PULSE_CYCLES - 1)) begin
                        state   <= ST_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
                        tcnt    <= '0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (force_relock) begin
                        state   <= ST_PLL_RST;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                    end else if (locked_s) begin
                        state <= ST_SETTLE;
                        cnt   <= '0;
                    end
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
                    else if (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        retry_count <= retry_count + RETRY_W'(1);
                        if (retry_count + RETRY_W'(1) == RETRY_W'(MAX_RETRIES)) begin
                            state <= ST_FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state   <= ST_PLL_RST;
                            cnt     <= '0;
                            pll_rst <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
`endif
                end
                ST_SETTLE: begin
                    if (force_relock) begin
                        state   <= ST_PLL_RST;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                    end else if (!locked_s) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state   <= ST_RUN;
                        cnt     <= '0;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
                        retry_count <= '0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // loss of lock takes priority over a coincident relock request
                    if (!locked_s || force_relock) begin
                        state   <= ST_PLL_RST;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        sys_rst <= 1'b1;
                        ready   <= 1'b0;
                        if (!locked_s) begin
                            lock_lost <= 1'b1;
                            if (relock_count != '1) begin
                                relock_count <= relock_count + RELOCK_W'(1);
                            end
                        end
                    end
                end
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
                ST_FAIL: begin
                    if (force_relock) begin
                        state       <= ST_PLL_RST;
                        cnt         <= '0;
                        pll_rst     <= 1'b1;
                        fail        <= 1'b0;
                        retry_count <= '0;
                    end
                end
`endif
                default: begin
                    state   <= ST_PLL_RST;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor; timeout expectations follow PLL_SUPERVISOR_TIMEOUT_EN.
module tb_pll_lock_supervisor;

`ifdef PLL_SUPERVISOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] relock_count;

    int vectors     = 0;
    int miscompares = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES (4),
        .SETTLE_CYCLES    (8),
        .TIMEOUT_CYCLES   (32),
        .MAX_RETRIES      (2)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .fail         (fail),
        .retry_count  (retry_count),
        .relock_count (relock_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"},   32'(pll_rst),      32'd1);
        check({tag, "_sys_rst"},   32'(sys_rst),      32'd1);
        check({tag, "_ready"},     32'(ready),        32'd0);
        check({tag, "_lock_lost"}, 32'(lock_lost),    32'd0);
        check({tag, "_fail"},      32'(fail),         32'd0);
        check({tag, "_retry"},     32'(retry_count),  32'd0);
        check({tag, "_relock"},    32'(relock_count), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        step(3);
        check_reset_values("rst_hold");

        // Power-up: 4-cycle PLL reset, lock 10 cycles after release, ready 11 later
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check("boot_pll_rst", 32'(pll_rst), 32'(i < 4));
        end
        check("boot_sys_rst", 32'(sys_rst), 32'd1);
        step(6);
        pll_locked = 1'b1;
        step(10);
        check("boot_ready_early", 32'(ready), 32'd0);
        check("boot_sys_rst_early", 32'(sys_rst), 32'd1);
        step(1);
        check("boot_ready", 32'(ready), 32'd1);
        check("boot_sys_rst_rel", 32'(sys_rst), 32'd0);
        check("boot_retry", 32'(retry_count), 32'd0);

        // Loss of lock in RUN
        pll_locked = 1'b0;
        step(2);
        check("loss_sync_ready", 32'(ready), 32'd1);
        check("loss_sync_ll", 32'(lock_lost), 32'd0);
        step(1);
        check("loss_ll_pulse", 32'(lock_lost), 32'd1);
        check("loss_relock", 32'(relock_count), 32'd1);
        check("loss_ready", 32'(ready), 32'd0);
        check("loss_sys_rst", 32'(sys_rst), 32'd1);
        check("loss_pll_rst", 32'(pll_rst), 32'd1);
        step(1);
        check("loss_ll_clear", 32'(lock_lost), 32'd0);
        step(2);
        check("loss_pll_rst_hold", 32'(pll_rst), 32'd1);
        step(1);
        check("loss_pll_rst_end", 32'(pll_rst), 32'd0);
        pll_locked = 1'b1;
        step(10);
        check("relock_ready_early", 32'(ready), 32'd0);
        step(1);
        check("relock_ready", 32'(ready), 32'd1);

        // force_relock alone in RUN, then a lock glitch at settle count 5
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        check("force_no_ll", 32'(lock_lost), 32'd0);
        check("force_pll_rst", 32'(pll_rst), 32'd1);
        check("force_ready", 32'(ready), 32'd0);
        check("force_relock_cnt", 32'(relock_count), 32'd1);
        step(10);
        pll_locked = 1'b0;
        step(3);
        check("glitch_no_ready", 32'(ready), 32'd0);
        pll_locked = 1'b1;
        step(10);
        check("glitch_restart_early", 32'(ready), 32'd0);
        step(1);
        check("glitch_restart_ready", 32'(ready), 32'd1);

        // Lock loss coinciding with force_relock at the FSM
        pll_locked = 1'b0;
        step(2);
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        check("both_ll", 32'(lock_lost), 32'd1);
        check("both_relock", 32'(relock_count), 32'd2);
        check("both_pll_rst", 32'(pll_rst), 32'd1);
        step(1);
        check("both_ll_clear", 32'(lock_lost), 32'd0);

        // Lock never arrives: timeouts and FAIL when enabled, indefinite wait otherwise
        step(3);
        check("to_wait_pll_rst", 32'(pll_rst), 32'd0);
        step(31);
        check("to1_before_retry", 32'(retry_count), 32'd0);
        step(1);
        check("to1_retry", 32'(retry_count), TO_EN ? 32'd1 : 32'd0);
        check("to1_pll_rst", 32'(pll_rst), 32'(TO_EN));
        step(4);
        check("to2_wait_pll_rst", 32'(pll_rst), 32'd0);
        step(31);
        check("to2_before_retry", 32'(retry_count), TO_EN ? 32'd1 : 32'd0);
        check("to2_before_fail", 32'(fail), 32'd0);
        step(1);
        check("to2_fail", 32'(fail), 32'(TO_EN));
        check("to2_retry", 32'(retry_count), TO_EN ? 32'd2 : 32'd0);
        check("to2_pll_rst", 32'(pll_rst), 32'd0);
        check("to2_sys_rst", 32'(sys_rst), 32'd1);
        step(3);
        check("fail_hold", 32'(fail), 32'(TO_EN));
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        check("exit_fail", 32'(fail), 32'd0);
        check("exit_retry", 32'(retry_count), 32'd0);
        check("exit_pll_rst", 32'(pll_rst), 32'd1);

        // Asynchronous reset in SETTLE
        pll_locked = 1'b1;
        step(8);
        check("settle_ready", 32'(ready), 32'd0);
        check("settle_relock", 32'(relock_count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        step(1);
        check("rst_held_pll_rst", 32'(pll_rst), 32'd1);
        rst = 1'b0;
        step(3);
        check("rerun_pll_rst", 32'(pll_rst), 32'd1);
        step(1);
        check("rerun_pll_rst_end", 32'(pll_rst), 32'd0);
        step(8);
        check("rerun_ready_early", 32'(ready), 32'd0);
        step(1);
        check("rerun_ready", 32'(ready), 32'd1);
        check("rerun_sys_rst", 32'(sys_rst), 32'd0);
        check("rerun_relock", 32'(relock_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
